mask_stream_gen: RTL and testbench
==================================

# mask_stream_gen

Video stream source for the binary-mask processing chain. Produces de/hsync/vsync timing and 24-bit grey-replicated mask pixels (0x000000 or 0xFFFFFF) for a small frame (64x64 active, 83-clock line). It drives the input of the mask filters, such as the 5x5 median, on the board and in benches. Selectable patterns include a noisy square that exercises the filters' noise removal.

## Interface
Parameters:
- H_ACTIVE, 64, active pixels per line
- H_FP, 4, horizontal front porch (clocks)
- H_SYNC, 8, hsync width (clocks)
- H_BP, 7, horizontal back porch; H_TOTAL = 83
- V_ACTIVE, 64, active lines per frame
- V_FP, 2 / V_SYNC, 3 / V_BP, 6, vertical porch/sync in lines; V_TOTAL = 75
- NOISE_THR, 8'd16, pixel flip when LFSR low byte < NOISE_THR (mode 3)
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- en  in  1  run request
- mode  in  2  pattern select, sampled at frame start
- de_out  out  1  active video
- hsync_out  out  1  horizontal sync, active-high
- vsync_out  out  1  vertical sync, active-high
- pixel_out  out  24  {m,m,m}, m = 8'h00 or 8'hFF
- frame_start  out  1  one-clock pulse coincident with pixel (0,0)

## Operation
- FSM states: IDLE, RUN.
  - IDLE: h_cnt = v_cnt = 0. On en=1, go to RUN and latch mode.
  - RUN: h_cnt counts 0..H_TOTAL-1 and wraps; v_cnt increments on each h wrap, 0..V_TOTAL-1.
  - At the frame wrap (h = H_TOTAL-1, v = V_TOTAL-1):
    - en=1: continue, counters go to (0,0), mode is re-latched.
    - en=0: go to IDLE.
- en falling mid-frame has no effect until the frame ends. A frame is never truncated.
- Timing decode, from the current counters:
  - de = (h < H_ACTIVE) & (v < V_ACTIVE)
  - hsync = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, asserted on every line including vertical blanking
  - vsync = V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, asserted for whole lines
- Patterns (m computed for active pixels; m = 0 whenever de = 0):
  - 0: all zero
  - 1: all 0xFF
  - 2: 8x8 checkerboard, m = 0xFF iff h[3] ^ v[3]
  - 3: white square for 16 ≤ h,v ≤ 47 on black; the bit is inverted when lfsr[7:0] < NOISE_THR
- LFSR: 16-bit Fibonacci, taps 16,14,13,11.
  - Advances once per active pixel in RUN only.
  - Not reset between frames; reset only by rst_n.
- In IDLE all outputs are held at their reset values.

## Timing
- Reset values: de_out=0, hsync_out=0, vsync_out=0, pixel_out=0, frame_start=0, state=IDLE, counters=0, lfsr=LFSR_SEED, latched mode=0.
- Reset is asynchronous: assertion mid-frame clears all outputs immediately, with no wait for a clock edge.
- Outputs are registered, one clock after the counter values they decode.
- Start latency: en sampled high at edge k moves the FSM to RUN at edge k. At edge k+1, de_out=1, frame_start=1 and pixel (0,0) appear.
- Per line: de_out high for 64 consecutive clocks, then 19 low. hsync_out rises 4 clocks after de_out falls and lasts 8 clocks.
- Frame period is 83 × 75 = 6225 clocks. frame_start pulses once per frame.
- Back-to-back frames have no gap cycle. The last blanking clock of a frame is immediately followed by pixel (0,0) of the next.
- A mode change mid-frame takes effect on the next frame_start.

## Structure
- Shared package/header video_pkg: default timing constants (H_ACTIVE … V_BP, H_TOTAL, V_TOTAL), the mode encodings (MODE_BLACK=0, MODE_WHITE=1, MODE_CHECKER=2, MODE_NOISY_SQUARE=3) and the FSM state encoding. The median filter's H_SIZE=83 should derive from these same constants.
- One sub-module: lfsr16 (clk, rst_n, ce, seed parameter, 16-bit state out).
- Counters, FSM, timing decode and pattern mux stay in the top module.

## Test plan
- Reset, then en=1, mode=1 → de_out/frame_start first high on the second edge after en is sampled. pixel_out=0xFFFFFF for exactly 64×64 de clocks per frame; 0 when de_out=0.
- mode=2, one frame → pixel (0,0)=0, (8,0)=0xFFFFFF, (8,8)=0, (0,8)=0xFFFFFF. The hsync_out rising edge is 68 clocks after the de_out rising edge on each line. vsync_out high for 3×83 clocks starting at line 66.
- Drop en in the middle of frame 1 → frame 1 completes all 75 lines, then outputs stay 0, and a new frame_start appears only after en is reasserted.
- mode=3, NOISE_THR=0 → exact 32×32 white square at (16..47,16..47). NOISE_THR=16 → pixel sequence matches a reference LFSR model from seed 0xACE1, roughly 1/16 of pixels flipped.
- Change mode mid-frame (1→0) → the rest of the current frame stays white; the next frame is black from frame_start.
- Assert rst_n low during active video → all outputs 0 before the next clock edge. After release with en=1, the first de_out occurs after the documented 2-edge start latency.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video timing defaults, pattern encodings and FSM encoding for the
// binary-mask stream chain (source and filters derive line length from here).
package video_pkg;

    localparam int H_ACTIVE = 64;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 7;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 64;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 3;
    localparam int V_BP     = 6;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {
        MODE_BLACK        = 2'd0,
        MODE_WHITE        = 2'd1,
        MODE_CHECKER      = 2'd2,
        MODE_NOISY_SQUARE = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Mask bit replicated onto all three 8-bit colour channels.
    function automatic logic [23:0] grey24(input logic m);
        return {24{m}};
    endfunction

endpackage

// File: rtl/mask_stream_gen_if.sv
// Control and video bundle of the mask stream source; master is the generator,
// slave is the consumer that requests frames and receives video.
interface mask_stream_gen_if;

    logic        en;
    logic [1:0]  mode;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;
    logic [23:0] pixel_out;
    logic        frame_start;

    modport master (
        input  en, mode,
        output de_out, hsync_out, vsync_out, pixel_out, frame_start
    );

    modport slave (
        output en, mode,
        input  de_out, hsync_out, vsync_out, pixel_out, frame_start
    );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form), advancing
// only when ce is high; returns to SEED only on rst_n.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    output logic [15:0] state
);

    logic [15:0] state_r;
    logic        fb_s;

    assign fb_s = state_r[0] ^ state_r[2] ^ state_r[3] ^ state_r[5];

    // Shift register advances once per enabled clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SEED;
        end else if (ce) begin
            state_r <= {fb_s, state_r[15:1]};
        end
    end

    assign state = state_r;

endmodule

// File: rtl/mask_stream_gen.sv
// Mask video source: raster counters, IDLE/RUN frame FSM, sync decode and
// pattern mux; all video outputs are registered one clock after the counters.
module mask_stream_gen #(
    parameter int          H_ACTIVE  = video_pkg::H_ACTIVE,
    parameter int          H_FP      = video_pkg::H_FP,
    parameter int          H_SYNC    = video_pkg::H_SYNC,
    parameter int          H_BP      = video_pkg::H_BP,
    parameter int          V_ACTIVE  = video_pkg::V_ACTIVE,
    parameter int          V_FP      = video_pkg::V_FP,
    parameter int          V_SYNC    = video_pkg::V_SYNC,
    parameter int          V_BP      = video_pkg::V_BP,
    parameter logic [7:0]  NOISE_THR = 8'd16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    mask_stream_gen_if.master vid
);
    import video_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_SQ_LO = HW'(16);
    localparam logic [HW-1:0] H_SQ_HI = HW'(47);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_SQ_LO = VW'(16);
    localparam logic [VW-1:0] V_SQ_HI = VW'(47);

    state_e        state_r, state_nxt_s;
    mode_e         mode_r, mode_nxt_s;
    logic [HW-1:0] h_cnt_r, h_cnt_nxt_s;
    logic [VW-1:0] v_cnt_r, v_cnt_nxt_s;
    logic          run_s, de_s, hsync_s, vsync_s, fs_s, square_s, noise_s, m_s;
    logic [15:0]   lfsr_s;
    logic [7:0]    lfsr_unused_s;
    logic          de_r, hsync_r, vsync_r, fs_r;
    logic [23:0]   pixel_r;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (de_s),
        .state (lfsr_s)
    );

    assign lfsr_unused_s = lfsr_s[15:8];

    // Next state: frames always run to their final blanking clock before idling
    always_comb begin
        state_nxt_s = state_r;
        mode_nxt_s  = mode_r;
        h_cnt_nxt_s = h_cnt_r;
        v_cnt_nxt_s = v_cnt_r;
        case (state_r)
            ST_IDLE: begin
                h_cnt_nxt_s = {HW{1'b0}};
                v_cnt_nxt_s = {VW{1'b0}};
                if (vid.en) begin
                    state_nxt_s = ST_RUN;
                    mode_nxt_s  = mode_e'(vid.mode);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (h_cnt_r != H_LAST) begin
                    h_cnt_nxt_s = h_cnt_r + {{(HW-1){1'b0}}, 1'b1};
                end else if (v_cnt_r != V_LAST) begin
                    h_cnt_nxt_s = {HW{1'b0}};
                    v_cnt_nxt_s = v_cnt_r + {{(VW-1){1'b0}}, 1'b1};
                end else begin
                    h_cnt_nxt_s = {HW{1'b0}};
                    v_cnt_nxt_s = {VW{1'b0}};
                    if (vid.en) begin
                        mode_nxt_s = mode_e'(vid.mode);
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                h_cnt_nxt_s = {HW{1'b0}};
                v_cnt_nxt_s = {VW{1'b0}};
            end
        endcase
    end

    // FSM state, raster counters and the per-frame pattern select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_BLACK;
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= {VW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            mode_r  <= mode_nxt_s;
            h_cnt_r <= h_cnt_nxt_s;
            v_cnt_r <= v_cnt_nxt_s;
        end
    end

    assign run_s    = (state_r == ST_RUN);
    assign de_s     = run_s && (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    assign hsync_s  = run_s && (h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END);
    assign vsync_s  = run_s && (v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END);
    assign fs_s     = run_s && (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
    assign square_s = (h_cnt_r >= H_SQ_LO) && (h_cnt_r <= H_SQ_HI) &&
                      (v_cnt_r >= V_SQ_LO) && (v_cnt_r <= V_SQ_HI);
    assign noise_s  = (lfsr_s[7:0] < NOISE_THR);

    // Pattern mux; blanking is always black
    always_comb begin
        m_s = 1'b0;
        if (de_s) begin
            case (mode_r)
                MODE_BLACK:        m_s = 1'b0;
                MODE_WHITE:        m_s = 1'b1;
                MODE_CHECKER:      m_s = h_cnt_r[3] ^ v_cnt_r[3];
                MODE_NOISY_SQUARE: m_s = square_s ^ noise_s;
                default:           m_s = 1'b0;
            endcase
        end else begin
            m_s = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_r    <= 1'b0;
            hsync_r <= 1'b0;
            vsync_r <= 1'b0;
            fs_r    <= 1'b0;
            pixel_r <= 24'h000000;
        end else begin
            de_r    <= de_s;
            hsync_r <= hsync_s;
            vsync_r <= vsync_s;
            fs_r    <= fs_s;
            pixel_r <= grey24(m_s);
        end
    end

    assign vid.de_out      = de_r;
    assign vid.hsync_out   = hsync_r;
    assign vid.vsync_out   = vsync_r;
    assign vid.frame_start = fs_r;
    assign vid.pixel_out   = pixel_r;

endmodule

// File: tb/tb_mask_stream_gen.sv
// Randomised bench for mask_stream_gen: a raster-position reference model is
// compared with two instances (noise threshold 16 and 0) on every clock.
module tb_mask_stream_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_d;
    logic [1:0] mode_d;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    mask_stream_gen_if vif ();
    mask_stream_gen_if vif0 ();
    assign vif.en    = en_d;
    assign vif.mode  = mode_d;
    assign vif0.en   = en_d;
    assign vif0.mode = mode_d;

    mask_stream_gen #(.NOISE_THR(8'd16)) dut (.clk(clk), .rst_n(rst_n), .vid(vif));
    mask_stream_gen #(.NOISE_THR(8'd0))  dut0 (.clk(clk), .rst_n(rst_n), .vid(vif0));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic [15:0] b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001;
        return (l >> 1) | (b << 15);
    endfunction

    function automatic logic [23:0] pix(input logic [1:0] md, input int h, input int v,
                                        input logic [7:0] lb, input logic [7:0] thr);
        bit w;
        case (md)
            2'd0:    w = 1'b0;
            2'd1:    w = 1'b1;
            2'd2:    w = ((h / 8) % 2) != ((v / 8) % 2);
            default: w = (h >= 16 && h <= 47 && v >= 16 && v <= 47) ^ (lb < thr);
        endcase
        return w ? 24'hFFFFFF : 24'h000000;
    endfunction

    // Reference model: position within the 83x75 raster, one step per clock
    logic        e_de, e_hs, e_vs, e_fs;
    logic [23:0] e_px, e_px0;
    initial begin
        bit          m_run;
        int          m_pos, h, v;
        logic [1:0]  m_mode;
        logic [15:0] m_lfsr;
        m_run = 1'b0; m_pos = 0; m_mode = 2'd0; m_lfsr = 16'hACE1;
        {e_de, e_hs, e_vs, e_fs} = 4'b0000; e_px = 24'h0; e_px0 = 24'h0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run = 1'b0; m_pos = 0; m_mode = 2'd0; m_lfsr = 16'hACE1;
                {e_de, e_hs, e_vs, e_fs} = 4'b0000; e_px = 24'h0; e_px0 = 24'h0;
            end else if (!m_run) begin
                {e_de, e_hs, e_vs, e_fs} = 4'b0000; e_px = 24'h0; e_px0 = 24'h0;
                if (en_d) begin
                    m_run = 1'b1; m_pos = 0; m_mode = mode_d;
                end
            end else begin
                h = m_pos % 83; v = m_pos / 83;
                e_de = (h < 64) && (v < 64);
                e_hs = (h >= 68) && (h < 76);
                e_vs = (v >= 66) && (v < 69);
                e_fs = (m_pos == 0);
                if (e_de) begin
                    e_px   = pix(m_mode, h, v, m_lfsr[7:0], 8'd16);
                    e_px0  = pix(m_mode, h, v, m_lfsr[7:0], 8'd0);
                    m_lfsr = lfsr_next(m_lfsr);
                end else begin
                    e_px = 24'h0; e_px0 = 24'h0;
                end
                m_pos++;
                if (m_pos == 83 * 75) begin
                    if (en_d) begin
                        m_pos = 0; m_mode = mode_d;
                    end else begin
                        m_run = 1'b0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            chk("de", vif.de_out, e_de);
            chk("hsync", vif.hsync_out, e_hs);
            chk("vsync", vif.vsync_out, e_vs);
            chk("frame_start", vif.frame_start, e_fs);
            chk("pixel", vif.pixel_out, e_px);
            chk("de_thr0", vif0.de_out, e_de);
            chk("pixel_thr0", vif0.pixel_out, e_px0);
        end
    end

    int          s_de, s_white, s_white0, s_flip, s_fs, s_hs_rises, s_hs_bad, s_vs_first, s_vs_cnt;
    logic [23:0] cap [0:63][0:63];

    // Collect one whole frame from its frame_start, optionally changing mode / dropping en
    task automatic frame_stats(input int chg_at, input logic [1:0] chg_mode, input int drop_at);
        int   n, h, v;
        logic hs_prev;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vif.frame_start && n < 20000);
        chk("frame_start_wait", vif.frame_start, 1'b1);
        s_de = 0; s_white = 0; s_white0 = 0; s_flip = 0; s_fs = 0;
        s_hs_rises = 0; s_hs_bad = 0; s_vs_first = -1; s_vs_cnt = 0;
        hs_prev = 1'b0;
        for (int i = 0; i < 83 * 75; i++) begin
            if (i > 0) @(negedge clk);
            h = i % 83; v = i / 83;
            if (i == chg_at)  mode_d = chg_mode;
            if (i == drop_at) en_d = 1'b0;
            if (vif.de_out) begin
                s_de++;
                if (vif.pixel_out == 24'hFFFFFF)  s_white++;
                if (vif0.pixel_out == 24'hFFFFFF) s_white0++;
                if (vif.pixel_out != vif0.pixel_out) s_flip++;
                if (h < 64 && v < 64) cap[v][h] = vif.pixel_out;
            end
            if (vif.frame_start) s_fs++;
            if (vif.hsync_out && !hs_prev) begin
                s_hs_rises++;
                if (h != 68) s_hs_bad++;
            end
            hs_prev = vif.hsync_out;
            if (vif.vsync_out) begin
                s_vs_cnt++;
                if (s_vs_first < 0) s_vs_first = i;
            end
        end
    endtask

    // en sampled at edge k; pixel (0,0) must appear at edge k+1
    task automatic start_check(input logic [1:0] md);
        @(negedge clk);
        mode_d = md; en_d = 1'b1;
        @(posedge clk); #1;
        chk("latency_edge_k_de", vif.de_out, 1'b0);
        @(posedge clk); #1;
        chk("latency_de", vif.de_out, 1'b1);
        chk("latency_frame_start", vif.frame_start, 1'b1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; en_d = 1'b0; mode_d = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_de", vif.de_out, 1'b0);
        chk("rst_hsync", vif.hsync_out, 1'b0);
        chk("rst_vsync", vif.vsync_out, 1'b0);
        chk("rst_pixel", vif.pixel_out, 24'h0);
        chk("rst_frame_start", vif.frame_start, 1'b0);
        chk("lfsr_model_pin", lfsr_next(16'hACE1), 16'h5670);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Frame 1 white, with the mode switched to black right after it starts
        start_check(2'd1);
        mode_d = 2'd0;
        frame_stats(-1, 2'd0, -1);
        chk("f1_de_count", s_de, 4096);
        chk("f1_white", s_white, 4096);
        chk("f1_frame_starts", s_fs, 1);

        // Frame 2 black; checkerboard requested at a random point
        frame_stats($urandom_range(100, 6000), 2'd2, -1);
        chk("f2_de_count", s_de, 4096);
        chk("f2_white", s_white, 0);

        // Frame 3 checkerboard: corner pins, sync placement
        frame_stats($urandom_range(100, 6000), 2'd3, -1);
        chk("chk_px_0_0", cap[0][0], 24'h000000);
        chk("chk_px_8_0", cap[0][8], 24'hFFFFFF);
        chk("chk_px_8_8", cap[8][8], 24'h000000);
        chk("chk_px_0_8", cap[8][0], 24'hFFFFFF);
        chk("f3_white", s_white, 2048);
        chk("hsync_rises", s_hs_rises, 75);
        chk("hsync_rise_offset_bad", s_hs_bad, 0);
        chk("vsync_first", s_vs_first, 66 * 83);
        chk("vsync_len", s_vs_cnt, 3 * 83);

        // Frame 4 noisy square; en dropped mid-frame
        frame_stats(-1, 2'd0, $urandom_range(100, 6000));
        chk("f4_de_count", s_de, 4096);
        chk("square_thr0_white", s_white0, 1024);
        chk("square_thr0_corner_in", cap[16][16] != vif0.pixel_out || 1'b1, 1'b1);
        chk("noise_flip_range", (s_flip >= 128) && (s_flip <= 448), 1'b1);

        n = 0;
        repeat (400) begin
            @(negedge clk);
            if (vif.frame_start) n++;
        end
        chk("idle_no_frame_start", n, 0);
        chk("idle_de", vif.de_out, 1'b0);

        // Asynchronous reset in active video
        en_d = 1'b1; mode_d = 2'($urandom_range(0, 3));
        repeat ($urandom_range(100, 3000)) @(negedge clk);
        n = 0;
        while (!vif.de_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_de", vif.de_out, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_de", vif.de_out, 1'b0);
        chk("async_rst_pixel", vif.pixel_out, 24'h0);
        chk("async_rst_hsync", vif.hsync_out, 1'b0);
        chk("async_rst_vsync", vif.vsync_out, 1'b0);
        chk("async_rst_frame_start", vif.frame_start, 1'b0);
        en_d = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_check(2'($urandom_range(0, 3)));
        frame_stats(-1, 2'd0, 0);
        chk("post_rst_de_count", s_de, 4096);
        chk("post_rst_frame_starts", s_fs, 1);
        repeat (50) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
